// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if
// Byte-accept handshake between a producer and serial_frame_tx.
//
// Handshake: a byte transfers on a rising clock edge where Tx_Valid and
// Tx_Ready are both high. The producer holds Tx_Data stable while Tx_Valid
// is high and not yet accepted; Tx_Ready does not depend on Tx_Valid.
//
// Signals:
//   Tx_Data  [DATA_WIDTH-1:0]  byte to transmit (producer -> transmitter)
//   Tx_Valid                   Tx_Data holds a byte (producer -> transmitter)
//   Tx_Ready                   transmitter is idle (transmitter -> producer)
interface serial_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] Tx_Data;
  logic                  Tx_Valid;
  logic                  Tx_Ready;

  modport master (
    output Tx_Data,
    output Tx_Valid,
    input  Tx_Ready
  );

  modport slave (
    input  Tx_Data,
    input  Tx_Valid,
    output Tx_Ready
  );
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Serialises one byte per handshake as an asynchronous frame: a start bit
// (0), DATA_WIDTH data bits LSB first, and a stop bit (1). Each bit lasts
// CLKS_PER_BIT clock cycles. The idle line level is high.
//
// Ports:
//   CLOCK_50     system clock, rising edge
//   Reset_n      asynchronous active-low reset; aborts any frame
//   bus          slave side of the byte handshake (Tx_Data/Tx_Valid/Tx_Ready)
//   Serial_Data  serial line, driven straight from a flop
//   Tx_Busy      high while a frame is on the line (START, DATA, STOP)
//   Tx_Done      one-cycle pulse in the cycle after the stop bit ends
//   state_dbg    current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
module serial_frame_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8
) (
  input  logic              CLOCK_50,
  input  logic              Reset_n,
  serial_frame_tx_if.slave  bus,
  output logic              Serial_Data,
  output logic              Tx_Busy,
  output logic              Tx_Done,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_q;

  logic bit_end;
  assign bit_end = (bit_cnt == LAST_CNT);

  assign bus.Tx_Ready = (state == IDLE);
  assign Tx_Busy      = (state != IDLE);
  assign state_dbg    = state;

  // The line value for the next bit period is registered on the boundary
  // itself, so Serial_Data only ever changes on bit boundaries.
  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      Serial_Data <= 1'b1;
      Tx_Done     <= 1'b0;
    end else begin
      Tx_Done <= 1'b0;
      case (state)
        IDLE: begin
          Serial_Data <= 1'b1;
          bit_cnt     <= '0;
          bit_idx     <= '0;
          if (bus.Tx_Valid) begin
            shift_q     <= bus.Tx_Data;
            Serial_Data <= 1'b0;
            state       <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt     <= '0;
            bit_idx     <= '0;
            Serial_Data <= shift_q[0];
            state       <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == LAST_IDX) begin
              Serial_Data <= 1'b1;
              state       <= STOP;
            end else begin
              // shift_q[0] is on the line now; shift_q[1] is the next bit.
              Serial_Data <= shift_q[1];
              shift_q     <= {1'b0, shift_q[DATA_WIDTH-1:1]};
              bit_idx     <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            bit_cnt     <= '0;
            Serial_Data <= 1'b1;
            Tx_Done     <= 1'b1;
            state       <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          Serial_Data <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx
// Drives two transmitters (4 and 434 clocks per bit) with directed frames
// and compares the line, busy, done and ready outputs cycle by cycle against
// hand-computed line patterns.
module tb_serial_frame_tx;

  localparam int CPB_A = 4;
  localparam int CPB_B = 434;

  // clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.DATA_WIDTH(8)) bus_a ();
  serial_frame_tx_if #(.DATA_WIDTH(8)) bus_b ();

  logic       serial_a, busy_a, done_a;
  logic       serial_b, busy_b, done_b;
  logic [1:0] dbg_a, dbg_b;

  serial_frame_tx #(.CLKS_PER_BIT(CPB_A), .DATA_WIDTH(8)) dut_a (
    .CLOCK_50    (clk),
    .Reset_n     (rst_n),
    .bus         (bus_a),
    .Serial_Data (serial_a),
    .Tx_Busy     (busy_a),
    .Tx_Done     (done_a),
    .state_dbg   (dbg_a)
  );

  serial_frame_tx #(.CLKS_PER_BIT(CPB_B), .DATA_WIDTH(8)) dut_b (
    .CLOCK_50    (clk),
    .Reset_n     (rst_n),
    .bus         (bus_b),
    .Serial_Data (serial_b),
    .Tx_Busy     (busy_b),
    .Tx_Done     (done_b),
    .state_dbg   (dbg_b)
  );

  // scoreboard counters
  int total;
  int bad;

  task automatic check(input string what, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", what, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input bit sel, input logic [7:0] data, input logic valid);
    if (sel) begin
      bus_b.Tx_Data  = data;
      bus_b.Tx_Valid = valid;
    end else begin
      bus_a.Tx_Data  = data;
      bus_a.Tx_Valid = valid;
    end
  endtask

  task automatic sample(input bit sel, output logic line, output logic busy,
                        output logic done, output logic ready);
    if (sel) begin
      line = serial_b; busy = busy_b; done = done_b; ready = bus_b.Tx_Ready;
    end else begin
      line = serial_a; busy = busy_a; done = done_a; ready = bus_a.Tx_Ready;
    end
  endtask

  // mode 0: drop valid after accept; 1: hold valid with 8'hFF during the
  // frame; 2: keep valid high with next_data for a back-to-back frame.
  task automatic run_frame(input bit sel, input int cpb, input logic [7:0] data,
                           input logic [9:0] exp_line, input int mode,
                           input logic [7:0] next_data, input string name);
    logic       line, busy, done, ready;
    logic [7:0] rx;
    int         n, p, busy_cnt;
    drive(sel, data, 1'b1);
    #1;
    n = 0;
    sample(sel, line, busy, done, ready);
    while (!ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
      sample(sel, line, busy, done, ready);
    end
    check({name, " accept_ready"}, int'(ready), 1);
    rx = 8'h00;
    busy_cnt = 0;
    for (int k = 1; k <= 10 * cpb + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        case (mode)
          1:       drive(sel, 8'hFF, 1'b1);
          2:       drive(sel, next_data, 1'b1);
          default: drive(sel, 8'($urandom_range(0, 255)), 1'b0);
        endcase
      end
      sample(sel, line, busy, done, ready);
      if (k <= 10 * cpb) begin
        p = (k - 1) / cpb;
        check($sformatf("%s line c%0d", name, k), int'(line), int'(exp_line[9 - p]));
        check($sformatf("%s busy c%0d", name, k), int'(busy), 1);
        check($sformatf("%s done c%0d", name, k), int'(done), 0);
        if (busy) busy_cnt++;
        if (p >= 1 && p <= 8 && ((k - 1) % cpb) == cpb / 2) rx[p - 1] = line;
      end else begin
        check({name, " done_pulse"}, int'(done), 1);
        check({name, " ready_at_done"}, int'(ready), 1);
        check({name, " line_at_done"}, int'(line), 1);
        check({name, " busy_cycles"}, busy_cnt, 10 * cpb);
        check({name, " loopback"}, int'(rx), int'(data));
        if (mode == 1) drive(sel, 8'hFF, 1'b0);
      end
    end
    if (mode == 1) begin
      @(negedge clk);
      sample(sel, line, busy, done, ready);
      check({name, " single_frame_busy"}, int'(busy), 0);
      check({name, " single_frame_done"}, int'(done), 0);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // time order, MSB first: start, d0..d7, stop
    int         mode;
    logic [7:0] next;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic line, busy, done, ready;
    total = 0;
    bad   = 0;
    vecs[0] = '{data: 8'hA5, line: 10'b0_10100101_1, mode: 0, next: 8'h00};
    vecs[1] = '{data: 8'h3C, line: 10'b0_00111100_1, mode: 1, next: 8'h00};
    vecs[2] = '{data: 8'h01, line: 10'b0_10000000_1, mode: 2, next: 8'h80};
    vecs[3] = '{data: 8'h80, line: 10'b0_00000001_1, mode: 0, next: 8'h00};

    // reset
    rst_n = 1'b0;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("rst line", int'(serial_a), 1);
    check("rst ready", int'(bus_a.Tx_Ready), 1);
    check("rst busy", int'(busy_a), 0);
    check("rst done", int'(done_a), 0);
    check("rst state", int'(dbg_a), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("idle line c%0d", i), int'(serial_a), 1);
      check($sformatf("idle ready c%0d", i), int'(bus_a.Tx_Ready), 1);
    end

    // table-driven frames
    for (int v = 0; v < 4; v++) begin
      run_frame(0, CPB_A, vecs[v].data, vecs[v].line, vecs[v].mode, vecs[v].next,
                $sformatf("vec%0d", v));
    end
    repeat (3) @(negedge clk);

    // reset during data bit 3 of 8'h00
    drive(0, 8'h00, 1'b1);
    #1;
    check("mid accept_ready", int'(bus_a.Tx_Ready), 1);
    @(negedge clk);
    drive(0, 8'h00, 1'b0);
    repeat (17) @(negedge clk);   // cycle T+18, inside data bit 3
    check("mid line_before", int'(serial_a), 0);
    check("mid state_before", int'(dbg_a), 2);
    #1 rst_n = 1'b0;
    #1;
    sample(0, line, busy, done, ready);
    check("mid line_async", int'(line), 1);
    check("mid busy_async", int'(busy), 0);
    check("mid done_async", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("mid no_done c%0d", i), int'(done_a), 0);
      check($sformatf("mid idle_line c%0d", i), int'(serial_a), 1);
    end
    run_frame(0, CPB_A, 8'h55, 10'b0_10101010_1, 0, 8'h00, "after_rst");

    // real bit rate
    run_frame(1, CPB_B, 8'hFF, 10'b0_11111111_1, 0, 8'h00, "rate");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Transmit-side counterpart of the 8-bit serial receive path in the serial audio link.
- Accepts one parallel byte (audio sample slice) per valid/ready handshake.
- Serialises it onto a single line as an asynchronous frame: start bit, 8 data bits LSB first, stop bit.
- Idle line level is high, so a receiving shift register resetting to 8'hFF sees no spurious data.

Parameters:
CLKS_PER_BIT, 434, CLOCK_50 cycles per serial bit period (434 gives ~115200 baud at 50 MHz); legal range 2..65535.
DATA_WIDTH, 8, data bits per frame; this block is verified only at 8.

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge.
Reset_n  input  1  asynchronous, active-low reset.
Tx_Data  input  DATA_WIDTH  byte to transmit; sampled only on the accept cycle.
Tx_Valid  input  1  request; Tx_Data is valid.
Tx_Ready  output  1  high when the block can accept a byte (state IDLE).
Serial_Data  output  1  registered serial line output.
Tx_Busy  output  1  high while a frame is on the line (START, DATA, STOP).
Tx_Done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- States: IDLE, START, DATA, STOP. Registered state, bit-period counter (clog2(CLKS_PER_BIT) bits), bit index (0..7), shift register.
- Reset (Reset_n low, asynchronous), held until release:
  - state IDLE; Serial_Data 1; Tx_Busy 0; Tx_Done 0; Tx_Ready 1.
  - counter, bit index and shift register cleared.
- Tx_Ready = (state == IDLE), decoded combinationally from state. Tx_Busy = not IDLE.
- Accept: the cycle T where Tx_Valid && Tx_Ready.
  - At the end of T, Tx_Data is loaded into the shift register and state goes to START.
  - Serial_Data goes to 0 and the counter goes to 0.
  - Tx_Data and Tx_Valid are ignored at all other times. Changing Tx_Data after accept does not affect the frame.
- START: Serial_Data = 0 for cycles T+1 .. T+CLKS_PER_BIT. Then go to DATA with the bit index at 0.
- DATA:
  - Bit i (i = 0..7, LSB first) is driven for exactly CLKS_PER_BIT cycles, starting at T+1+(i+1)*CLKS_PER_BIT.
  - The shift register shifts right one place per bit period.
  - After bit 7's period, go to STOP.
- STOP: Serial_Data = 1 for CLKS_PER_BIT cycles, ending at cycle T+10*CLKS_PER_BIT.
- Completion: at the end of cycle T+10*CLKS_PER_BIT, state goes to IDLE and Tx_Done goes to 1 for exactly one cycle (cycle T+10*CLKS_PER_BIT+1). In that same cycle Tx_Ready = 1.
- Back-to-back frames:
  - If Tx_Valid is high in the Tx_Done cycle, that byte is accepted.
  - Its start bit begins one cycle later, so the minimum gap between frames is exactly 1 idle-high cycle.
- Frame length: exactly 10*CLKS_PER_BIT cycles of line activity per byte.
- Counter: counts 0..CLKS_PER_BIT-1, then wraps to 0 on each bit boundary. There is no cumulative drift.
- Glitch-free output: Serial_Data comes straight from a flop and changes only on bit boundaries.
- Reset mid-frame: the frame is aborted immediately, the line returns high asynchronously, and no Tx_Done is issued. After release, the block is idle and accepts a new byte normally.
- Tx_Valid held low: the block stays in IDLE indefinitely with the line at 1.

Test Plan:
- Reset check (CLKS_PER_BIT=4):
  - Stimulus: Reset_n low, then release.
  - Required: Serial_Data=1, Tx_Ready=1, Tx_Busy=0, Tx_Done=0, and the line stays high for 50 cycles with Tx_Valid=0.
- Single frame:
  - Stimulus: CLKS_PER_BIT=4, Tx_Data=8'hA5 accepted at cycle T.
  - Required line sequence, 4 cycles per bit from T+1: 0 (start), 1,0,1,0,0,1,0,1, 1 (stop).
  - Required: Tx_Done pulses only at T+41, and Tx_Busy is high during T+1..T+40.
- Data hold:
  - Stimulus: accept 8'h3C, then change Tx_Data to 8'hFF and hold Tx_Valid high during the frame.
  - Required: the line carries 8'h3C, and exactly one frame is sent before Tx_Done.
- Back-to-back:
  - Stimulus: Tx_Valid held high with 8'h01 then 8'h80.
  - Required: the second start bit falls at the first frame's Tx_Done cycle + 1. A loopback through the 8-bit serial receive path yields 8'h01 then 8'h80.
- Reset mid-frame:
  - Stimulus: assert Reset_n low during data bit 3 of 8'h00.
  - Required: Serial_Data=1 within the same cycle (asynchronous) and no Tx_Done. A new byte, 8'h55, is then sent correctly.
- Real rate:
  - Stimulus: CLKS_PER_BIT=434, byte 8'hFF.
  - Required: frame length is exactly 4340 cycles from the start falling edge to the end of stop, and each bit period is exactly 434 cycles.
